// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined processor.
// Contents: opcode encodings, the NOP word and the fetch-FSM state type.
package cpu_pkg;

    localparam logic [3:0] OP_LW    = 4'h0;
    localparam logic [3:0] OP_SW    = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_MOV   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMPZ  = 4'h5;
    localparam logic [3:0] OP_JUMP  = 4'h6;
    localparam logic [3:0] OP_STOP  = 4'h7;
    localparam logic [3:0] OP_ADDF  = 4'h8;
    localparam logic [3:0] OP_MULTF = 4'h9;
    localparam logic [3:0] OP_SLT   = 4'hA;
    localparam logic [3:0] OP_NOP   = 4'hF;

    localparam logic [15:0] NOP_INSTR = 16'hF000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    function automatic logic is_stop(input logic [3:0] op);
        return op == OP_STOP;
    endfunction

endpackage

// File: rtl/if_halt_fsm.sv
// Fetch run/drain/halt controller: after a STOP reaches decode, wait for the
// pipeline to drain for DRAIN_CYCLES non-stalled cycles, then halt for good.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_RUN   | normal fetch
//   ST_DRAIN | STOP issued; PC frozen, NOPs fed to decode, counting cycles
//   ST_HALT  | absorbing; only reset leaves
module if_halt_fsm
    import cpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stop_seen,
    input  logic         stall,
    input  logic         redirect,
    output fetch_state_t state,
    output logic         halted
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    fetch_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (stop_seen) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                // A redirect here means the STOP was on the wrong path.
                if (redirect) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (!stall) begin
                    if (cnt_q == CNT_LAST) state_d = ST_HALT;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            halted  <= (state_d == ST_HALT);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC, instruction-memory address and IF/ID register, with
// stall/flush/redirect handling and STOP drain. Optional macro: IF_PERF_CNT_EN.
module if_stage
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int OP_WIDTH     = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] im_addr_o,
    input  logic [DATA_WIDTH-1:0] im_rD_i,
    input  logic                  stall_IF_ID_i,
    input  logic                  flush_IF_ID_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] PCD_o,
    output logic [DATA_WIDTH-1:0] instrD_o,
`ifdef IF_PERF_CNT_EN
    output logic [15:0]           fetch_cnt_o,
`endif
    output logic                  halted_o
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [OP_WIDTH-1:0]   opcode;
    fetch_state_t          state;
    logic                  in_run, in_halt;
    logic                  redirect_eff, stall_eff;
    logic                  load_real, stop_seen;

    assign im_addr_o = pc_q;
    assign opcode    = im_rD_i[DATA_WIDTH-1 -: OP_WIDTH];

    assign in_run  = (state == ST_RUN);
    assign in_halt = (state == ST_HALT);

    // HALT ignores both redirect and stall.
    assign redirect_eff = redirect_i & ~in_halt;
    assign stall_eff    = stall_IF_ID_i & ~in_halt;

    assign load_real = in_run & ~stall_IF_ID_i & ~flush_IF_ID_i & ~redirect_i;
    assign stop_seen = load_real & is_stop(opcode);

    if_halt_fsm #(
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) u_halt_fsm (
        .clk      (clk),
        .rst      (rst),
        .stop_seen(stop_seen),
        .stall    (stall_IF_ID_i),
        .redirect (redirect_i),
        .state    (state),
        .halted   (halted_o)
    );

    // PC parks on a STOP address instead of fetching past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (redirect_eff) begin
            pc_q <= redirect_pc_i;
        end else if (in_run && !stall_IF_ID_i && !stop_seen) begin
            pc_q <= pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PCD_o    <= '0;
            instrD_o <= DATA_WIDTH'(NOP_INSTR);
        end else if (redirect_eff || flush_IF_ID_i) begin
            PCD_o    <= '0;
            instrD_o <= DATA_WIDTH'(NOP_INSTR);
        end else if (!stall_eff) begin
            PCD_o    <= pc_q;
            instrD_o <= in_run ? im_rD_i : DATA_WIDTH'(NOP_INSTR);
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
        end else if (load_real && fetch_cnt_q != 16'hFFFF) begin
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed steps followed by random traffic, all
// checked against a cycle-level behavioural model of the fetch stage.
module tb_if_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  im_addr;
    logic [15:0] im_rD;
    logic        stall, flush, redirect;
    logic [7:0]  redirect_pc;
    logic [7:0]  pcd;
    logic [15:0] instr;
    logic        halted;
`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt;
`endif

    logic [15:0] mem [256];

    int tests = 0;
    int fails = 0;

    // Reference model state; m_drain_left > 0 means draining.
    logic [7:0]  m_pc, m_pcd;
    logic [15:0] m_instr;
    bit          m_halt;
    int          m_drain_left;
    int          m_cnt;

    always #5 clk = ~clk;

    assign im_rD = mem[im_addr];

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .im_addr_o    (im_addr),
        .im_rD_i      (im_rD),
        .stall_IF_ID_i(stall),
        .flush_IF_ID_i(flush),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .PCD_o        (pcd),
        .instrD_o     (instr),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt_o  (fetch_cnt),
`endif
        .halted_o     (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit f, input bit rd,
                              input logic [7:0] rpc);
        logic [15:0] w;
        w = mem[m_pc];
        if (r) begin
            m_pc = 8'h00; m_pcd = 8'h00; m_instr = 16'hF000;
            m_halt = 0; m_drain_left = 0; m_cnt = 0;
        end else if (m_halt) begin
            m_instr = 16'hF000;
            m_pcd   = f ? 8'h00 : m_pc;
        end else if (m_drain_left > 0) begin
            if (rd) begin
                m_pc = rpc; m_pcd = 8'h00; m_instr = 16'hF000; m_drain_left = 0;
            end else begin
                if (f) begin
                    m_pcd = 8'h00; m_instr = 16'hF000;
                end else if (!s) begin
                    m_pcd = m_pc; m_instr = 16'hF000;
                end
                if (!s) begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_halt = 1;
                end
            end
        end else begin
            if (rd) begin
                m_pc = rpc; m_pcd = 8'h00; m_instr = 16'hF000;
            end else if (f) begin
                m_pcd = 8'h00; m_instr = 16'hF000;
                if (!s) m_pc = m_pc + 8'd1;
            end else if (!s) begin
                m_pcd = m_pc; m_instr = w;
                if (m_cnt < 65535) m_cnt++;
                if (w[15:12] == 4'h7) m_drain_left = 3;
                else                  m_pc = m_pc + 8'd1;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit f, input bit rd,
                        input logic [7:0] rpc);
        rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
        #1;
        if (!r) chk("im_addr_pre", im_addr, m_pc);
        model_edge(r, s, f, rd, rpc);
        @(posedge clk);
        #1;
        chk("pcd", pcd, m_pcd);
        chk("instr", instr, m_instr);
        chk("halted", halted, m_halt);
        chk("im_addr", im_addr, m_pc);
`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, m_cnt);
`endif
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        mem[0] = 16'h2123; mem[1] = 16'h2456; mem[2] = 16'h4789; mem[3] = 16'hF000;
        mem[4] = 16'h2111; mem[5] = 16'h7000;
        mem[8'h10] = 16'h3001; mem[8'h20] = 16'h7000; mem[8'h30] = 16'h1234;
        mem[8'hFF] = 16'h2FFF;

        // reset, then free run with a two-cycle stall at PC=2
        step(1, 0, 0, 0, 8'h00);
        chk("rst_instr", instr, 16'hF000);
        step(0, 0, 0, 0, 8'h00);
        chk("run0", {pcd, instr}, {8'h00, 16'h2123});
        step(0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        chk("stall_hold", {im_addr, instr}, {8'h02, 16'h2456});
        step(0, 0, 0, 0, 8'h00);
        chk("resume", {pcd, instr}, {8'h02, 16'h4789});

        // redirect during stall
        step(0, 1, 0, 1, 8'h40);
        chk("redir_stall", {im_addr, pcd, instr}, {8'h40, 8'h00, 16'hF000});
        step(0, 0, 0, 0, 8'h00);
        chk("redir_follow", pcd, 8'h40);

        // STOP at 5: drain (with one stalled cycle), halt, ignore redirect
        step(0, 0, 0, 1, 8'h04);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        chk("stop_issued", instr, 16'h7000);
        step(0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        chk("not_yet_halted", halted, 1'b0);
        step(0, 0, 0, 0, 8'h00);
        chk("halted", {halted, im_addr}, {1'b1, 8'h05});
        step(0, 1, 0, 1, 8'h22);
        chk("halt_ignores_redir", {halted, im_addr}, {1'b1, 8'h05});

        // wrong-path STOP cancelled by redirect in DRAIN
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h20);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h10);
        step(0, 0, 0, 0, 8'h00);
        chk("wrong_path", {halted, pcd}, {1'b0, 8'h10});

        // STOP fetched in the same cycle as a redirect
        step(0, 0, 0, 1, 8'h20);
        step(0, 0, 0, 1, 8'h30);
        step(0, 0, 0, 0, 8'h00);
        chk("stop_vs_redir", instr, 16'h1234);

        // PC wrap and a flush cycle
        step(0, 0, 0, 1, 8'hFF);
        step(0, 0, 0, 0, 8'h00);
        chk("wrap", {pcd, im_addr}, {8'hFF, 8'h00});
        step(0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        // random traffic
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        step(1, 0, 0, 0, 8'h00);
        for (int n = 0; n < 800; n++) begin
            bit r, s, f, rd;
            r  = m_halt ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 149) == 0);
            s  = ($urandom_range(0, 4) == 0);
            f  = ($urandom_range(0, 7) == 0);
            rd = ($urandom_range(0, 6) == 0);
            step(r, s, f, rd, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Fetch stage of the 16-bit pipelined processor.
- Owns the PC, drives the instruction-memory address, and writes the IF/ID pipeline register that feeds the decode stage (PCD, instruction word).
- Applies hazard-unit stall/flush and EX-stage branch/jump redirects.
- Detects a fetched STOP and drains to a halt.

Parameters:
- DATA_WIDTH, 16, instruction word width.
- ADDR_WIDTH, 8, PC / instruction-memory address width.
- OP_WIDTH, 4, opcode field width (instr[15:12]).
- DRAIN_CYCLES, 3, non-stalled cycles spent in DRAIN before entering HALT.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- im_addr_o  output  ADDR_WIDTH  instruction-memory read address; equals current PC (combinational).
- im_rD_i  input  DATA_WIDTH  instruction word at im_addr_o, valid in the same cycle.
- stall_IF_ID_i  input  1  hazard-unit stall: hold PC and IF/ID.
- flush_IF_ID_i  input  1  hazard-unit flush: load NOP into IF/ID.
- redirect_i  input  1  taken branch (JMPZ) or JUMP resolved in EX.
- redirect_pc_i  input  ADDR_WIDTH  redirect target.
- PCD_o  output  ADDR_WIDTH  IF/ID registered PC.
- instrD_o  output  DATA_WIDTH  IF/ID registered instruction.
- halted_o  output  1  high in HALT state.

Behaviour:
- NOP word is 16'hF000 (opcode 4'b1111). STOP opcode is 4'b0111.
- Reset (rst=1 at edge), overriding everything:
  - PC=0, PCD_o=0, instrD_o=16'hF000.
  - FSM=RUN, drain counter=0, halted_o=0.
- PC update priority (high to low): rst > redirect_i > halt gating > stall_IF_ID_i > increment.
  - redirect_i: PC <= redirect_pc_i.
  - In DRAIN or HALT, PC holds.
  - Stall: PC holds.
  - Otherwise PC <= PC+1, wrapping 8'hFF -> 8'h00 with no flag.
- IF/ID register priority (high to low): rst > (redirect_i or flush_IF_ID_i) > stall_IF_ID_i > FSM gating > load.
  - redirect_i or flush_IF_ID_i: instrD_o <= NOP, PCD_o <= 0. Flush beats stall.
  - stall_IF_ID_i: hold both.
  - DRAIN/HALT: instrD_o <= NOP, PCD_o <= PC.
  - RUN: instrD_o <= im_rD_i, PCD_o <= PC.
- Latency: instruction at address A appears on instrD_o one cycle after PC==A with no stall.
- FSM states RUN, DRAIN, HALT:
  - RUN -> DRAIN: when im_rD_i[15:12]==STOP is loaded into IF/ID (RUN, no stall/flush/redirect). The STOP itself is passed to decode. PC does not advance past STOP; PC holds at STOP address.
  - DRAIN: counter increments on each cycle without stall.
    - If redirect_i arrives in DRAIN (STOP was wrong-path), go to RUN with PC <= redirect_pc_i and counter cleared.
    - Otherwise, go to HALT when counter reaches DRAIN_CYCLES-1 on a non-stalled cycle.
  - HALT: absorbing; redirect_i and stall ignored; only rst exits. halted_o=1 registered, asserted the cycle after entry.
- Simultaneous events:
  - STOP fetched in the same cycle as redirect_i: redirect wins, STOP discarded, FSM stays RUN.
  - STOP fetched under stall: no transition until the stall clears.
- Reset mid-DRAIN or in HALT: returns to RUN at PC=0 on the next edge.

Optional Feature:
- Macro IF_PERF_CNT_EN.
  - Defined: adds output fetch_cnt_o (16 bits). Reset 0. Increments by 1 on every cycle where a real (non-NOP-injected) instruction is loaded into IF/ID in RUN. Saturates at 16'hFFFF. Freezes in HALT.
  - Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package (cpu_pkg): opcode localparams (LW, SW, ADD, MOV, SUB, JMPZ, JUMP, STOP, ADDF, MULTF, SLT, NOP), NOP_INSTR=16'hF000, FSM state encoding (2-bit).
- Decode control logic imports the same opcodes.
- One natural sub-module: if_halt_fsm (RUN/DRAIN/HALT plus drain counter; inputs stop_seen, stall, redirect; outputs state, halted).
- PC and IF/ID registers stay in if_stage.

Test Plan:
- Reset then free run; mem[0..3]={2123,2456,4789,F000} -> PCD_o/instrD_o = 0/2123, 1/2456, 2/4789, 3/F000 on successive cycles.
- stall_IF_ID_i high 2 cycles at PC=2 -> PC stays 2, instrD_o holds 2456; resumes with 4789.
- redirect_i=1, redirect_pc_i=8'h40 while stall_IF_ID_i=1 -> next cycle instrD_o=F000, PCD_o=0, PC=0x40; following cycle PCD_o=0x40.
- mem[5]=7000 (STOP) -> instrD_o=7000 once, then F000; halted_o=1 after 3 non-stalled drain cycles; PC frozen at 5; later redirect ignored.
- STOP fetched, redirect to 0x10 one cycle later in DRAIN -> FSM back to RUN, PCD_o=0x10 next load, halted_o stays 0.
- PC=0xFF with no stall -> next PC=0x00; with IF_PERF_CNT_EN, fetch_cnt_o counts only real loads (flush cycles excluded).
